cb_control_sequencer: RTL and testbench

Control sequencer for the 8-bit CPU; sits directly upstream of the bus registers (A, B, IR, MAR, OUT) and drives their load/output-enable lines.
- A T-state ring counter (T1..T6) combined with the 4-bit opcode from the instruction register produces one control word per cycle.
- Registers sample the bus on the next rising edge of clk.
- Implements fetch (T1-T3) and execute (T4-T6) for the instruction set, halt, and a run/hold input for single-stepping.

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/cb_ring_counter.sv | 38 +++
 rtl/cb_control_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_cb_control_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the 8-bit CPU control sequencer and its users:
//   - opcode constants (upper nibble of IR)
//   - one-hot T-state constants T1..T6
//   - control-word bit indices, so datapath and bench agree on bit positions
//   - sequencer run/halt state type
//   - last_tstate(): final active T-state of each instruction
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int OPC_BITS = 4;

  localparam logic [OPC_BITS-1:0] OP_LDA = 4'b0000;
  localparam logic [OPC_BITS-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_BITS-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_BITS-1:0] OP_STA = 4'b0100;
  localparam logic [OPC_BITS-1:0] OP_LDI = 4'b0101;
  localparam logic [OPC_BITS-1:0] OP_JMP = 4'b0110;
  localparam logic [OPC_BITS-1:0] OP_OUT = 4'b1110;
  localparam logic [OPC_BITS-1:0] OP_HLT = 4'b1111;

  localparam int TS_W = 6;

  localparam logic [TS_W-1:0] T1 = 6'b000001;
  localparam logic [TS_W-1:0] T2 = 6'b000010;
  localparam logic [TS_W-1:0] T3 = 6'b000100;
  localparam logic [TS_W-1:0] T4 = 6'b001000;
  localparam logic [TS_W-1:0] T5 = 6'b010000;
  localparam logic [TS_W-1:0] T6 = 6'b100000;

  // Control-word bit positions
  localparam int CW_PC_INC   = 0;
  localparam int CW_PC_OUT   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_RAM_OUT  = 4;
  localparam int CW_RAM_WE   = 5;
  localparam int CW_IR_LOAD  = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_LOAD   = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LOAD   = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_OUT_LOAD = 13;
  localparam int CW_W        = 14;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  // Last T-state that does useful work for an opcode. HLT never advances past
  // T4, and undefined opcodes behave as a single-cycle NOP in T4.
  function automatic logic [TS_W-1:0] last_tstate(input logic [OPC_BITS-1:0] op);
    logic [TS_W-1:0] t_last;
    case (op)
      OP_LDA, OP_STA: t_last = T5;
      OP_ADD, OP_SUB: t_last = T6;
      default:        t_last = T4;
    endcase
    return t_last;
  endfunction

endpackage

// File: rtl/cb_ring_counter.sv
// -----------------------------------------------------------------------------
// cb_ring_counter
// Six-bit one-hot T-state ring counter for the control sequencer.
// Ports:
//   clk        in   system clock
//   clear      in   asynchronous active-low reset, forces T1
//   i_en       in   1 = advance on this rising edge
//   i_restart  in   with i_en, go to T1 instead of the next T-state
//   o_t_state  out  one-hot current T-state, bit0 = T1
// -----------------------------------------------------------------------------
module cb_ring_counter
  import cpu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            clear,
  input  logic            i_en,
  input  logic            i_restart,
  output logic [TS_W-1:0] o_t_state
);

  logic [TS_W-1:0] r_t_state;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_t_state <= T1;
    end else if (i_en) begin
      if (i_restart) begin
        r_t_state <= T1;
      end else begin
        // Rotate left; T6 wraps naturally to T1.
        r_t_state <= {r_t_state[TS_W-2:0], r_t_state[TS_W-1]};
      end
    end
  end

  assign o_t_state = r_t_state;

endmodule

// File: rtl/cb_control_sequencer.sv
// -----------------------------------------------------------------------------
// cb_control_sequencer
// Fetch/execute control sequencer for the 8-bit CPU. A one-hot T-state ring
// counter plus the IR opcode decode combinationally into the bus control word.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_RUN  | normal sequencing; ring advances while run=1
//   ST_HALT | HLT executed; control lines forced 0, T-state frozen, exit only
//           | through clear
//
// Parameters:
//   EARLY_END  1 = jump to T1 after the instruction's last active T-state,
//              0 = always walk all six T-states
//   OPC_W      opcode width (IR[7:4])
// Ports:
//   clk, clear (async active-low), run (advance enable), opcode (valid T4+)
//   t_state (one-hot, bit0=T1), halted, and the bus control lines
//   pc_inc .. out_load
// -----------------------------------------------------------------------------
module cb_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter bit EARLY_END = 1'b1,
  parameter int OPC_W     = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  output logic [5:0]       t_state,
  output logic             halted,
  output logic             pc_inc,
  output logic             pc_out,
  output logic             pc_load,
  output logic             mar_load,
  output logic             ram_out,
  output logic             ram_we,
  output logic             ir_load,
  output logic             ir_out,
  output logic             a_load,
  output logic             a_out,
  output logic             b_load,
  output logic             alu_out,
  output logic             alu_sub,
  output logic             out_load
);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic [TS_W-1:0]     w_t_state;
  logic [OPC_BITS-1:0] w_op;
  logic                w_ring_en;
  logic                w_restart;
  logic [CW_W-1:0]     w_cw;

  assign w_op = OPC_BITS'(opcode);

  cb_ring_counter u_ring (
    .clk       (clk),
    .clear     (clear),
    .i_en      (w_ring_en),
    .i_restart (w_restart),
    .o_t_state (w_t_state)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HLT in T4 enters ST_HALT without advancing, so t_state stays at T4.
  always_comb begin
    w_state_nxt = r_state;
    w_ring_en   = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (run) begin
          if ((w_t_state == T4) && (w_op == OP_HLT)) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_ring_en = 1'b1;
            w_restart = EARLY_END && (w_t_state == last_tstate(w_op));
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Control-word decode: fetch is opcode independent, execute keys on opcode.
  always_comb begin
    w_cw = '0;
    if (r_state == ST_RUN) begin
      case (w_t_state)
        T1: begin
          w_cw[CW_PC_OUT]   = 1'b1;
          w_cw[CW_MAR_LOAD] = 1'b1;
        end
        T2: begin
          w_cw[CW_PC_INC] = 1'b1;
        end
        T3: begin
          w_cw[CW_RAM_OUT] = 1'b1;
          w_cw[CW_IR_LOAD] = 1'b1;
        end
        T4: begin
          case (w_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              w_cw[CW_IR_OUT]   = 1'b1;
              w_cw[CW_MAR_LOAD] = 1'b1;
            end
            OP_LDI: begin
              w_cw[CW_IR_OUT] = 1'b1;
              w_cw[CW_A_LOAD] = 1'b1;
            end
            OP_JMP: begin
              w_cw[CW_IR_OUT]  = 1'b1;
              w_cw[CW_PC_LOAD] = 1'b1;
            end
            OP_OUT: begin
              w_cw[CW_A_OUT]    = 1'b1;
              w_cw[CW_OUT_LOAD] = 1'b1;
            end
            default: begin
              w_cw = '0;
            end
          endcase
        end
        T5: begin
          case (w_op)
            OP_LDA: begin
              w_cw[CW_RAM_OUT] = 1'b1;
              w_cw[CW_A_LOAD]  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              w_cw[CW_RAM_OUT] = 1'b1;
              w_cw[CW_B_LOAD]  = 1'b1;
            end
            OP_STA: begin
              w_cw[CW_A_OUT]  = 1'b1;
              w_cw[CW_RAM_WE] = 1'b1;
            end
            default: begin
              w_cw = '0;
            end
          endcase
        end
        T6: begin
          if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
            w_cw[CW_ALU_OUT] = 1'b1;
            w_cw[CW_A_LOAD]  = 1'b1;
            w_cw[CW_ALU_SUB] = (w_op == OP_SUB);
          end
        end
        default: begin
          w_cw = '0;
        end
      endcase
    end
  end

  assign t_state  = w_t_state;
  assign halted   = (r_state == ST_HALT);
  assign pc_inc   = w_cw[CW_PC_INC];
  assign pc_out   = w_cw[CW_PC_OUT];
  assign pc_load  = w_cw[CW_PC_LOAD];
  assign mar_load = w_cw[CW_MAR_LOAD];
  assign ram_out  = w_cw[CW_RAM_OUT];
  assign ram_we   = w_cw[CW_RAM_WE];
  assign ir_load  = w_cw[CW_IR_LOAD];
  assign ir_out   = w_cw[CW_IR_OUT];
  assign a_load   = w_cw[CW_A_LOAD];
  assign a_out    = w_cw[CW_A_OUT];
  assign b_load   = w_cw[CW_B_LOAD];
  assign alu_out  = w_cw[CW_ALU_OUT];
  assign alu_sub  = w_cw[CW_ALU_SUB];
  assign out_load = w_cw[CW_OUT_LOAD];

endmodule

// File: tb/tb_cb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cb_control_sequencer
// Two sequencers (EARLY_END=1 and EARLY_END=0) share the same stimulus. An
// integer step/halt model per instance predicts the T-state and control word,
// compared every cycle; directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_cb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       run = 1'b1;
  logic [3:0] opcode = OP_LDA;

  wire [5:0]      ts0, ts1;
  wire            h0, h1;
  wire [CW_W-1:0] cw0, cw1;

  int n_checks = 0;
  int n_fail   = 0;

  int m_step [2] = '{1, 1};
  bit m_halt [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  cb_control_sequencer #(.EARLY_END(1'b1), .OPC_W(4)) u_dut_ee1 (
    .clk(clk), .clear(clear), .run(run), .opcode(opcode),
    .t_state(ts0), .halted(h0),
    .pc_inc(cw0[CW_PC_INC]), .pc_out(cw0[CW_PC_OUT]), .pc_load(cw0[CW_PC_LOAD]),
    .mar_load(cw0[CW_MAR_LOAD]), .ram_out(cw0[CW_RAM_OUT]), .ram_we(cw0[CW_RAM_WE]),
    .ir_load(cw0[CW_IR_LOAD]), .ir_out(cw0[CW_IR_OUT]), .a_load(cw0[CW_A_LOAD]),
    .a_out(cw0[CW_A_OUT]), .b_load(cw0[CW_B_LOAD]), .alu_out(cw0[CW_ALU_OUT]),
    .alu_sub(cw0[CW_ALU_SUB]), .out_load(cw0[CW_OUT_LOAD])
  );

  cb_control_sequencer #(.EARLY_END(1'b0), .OPC_W(4)) u_dut_ee0 (
    .clk(clk), .clear(clear), .run(run), .opcode(opcode),
    .t_state(ts1), .halted(h1),
    .pc_inc(cw1[CW_PC_INC]), .pc_out(cw1[CW_PC_OUT]), .pc_load(cw1[CW_PC_LOAD]),
    .mar_load(cw1[CW_MAR_LOAD]), .ram_out(cw1[CW_RAM_OUT]), .ram_we(cw1[CW_RAM_WE]),
    .ir_load(cw1[CW_IR_LOAD]), .ir_out(cw1[CW_IR_OUT]), .a_load(cw1[CW_A_LOAD]),
    .a_out(cw1[CW_A_OUT]), .b_load(cw1[CW_B_LOAD]), .alu_out(cw1[CW_ALU_OUT]),
    .alu_sub(cw1[CW_ALU_SUB]), .out_load(cw1[CW_OUT_LOAD])
  );

  function automatic logic [CW_W-1:0] w(input int a = -1, input int b = -1, input int c = -1);
    logic [CW_W-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  // Number of T-states an instruction really needs.
  function automatic int m_last(input logic [3:0] op);
    if (op == OP_LDA || op == OP_STA) return 5;
    if (op == OP_ADD || op == OP_SUB) return 6;
    return 4;
  endfunction

  // Control word as listed in the instruction table.
  function automatic logic [CW_W-1:0] m_word(input int step, input logic [3:0] op, input bit hlt);
    if (hlt) return '0;
    if (step == 1) return w(CW_PC_OUT, CW_MAR_LOAD);
    if (step == 2) return w(CW_PC_INC);
    if (step == 3) return w(CW_RAM_OUT, CW_IR_LOAD);
    if (step == 4) begin
      if (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_STA) return w(CW_IR_OUT, CW_MAR_LOAD);
      if (op == OP_LDI) return w(CW_IR_OUT, CW_A_LOAD);
      if (op == OP_JMP) return w(CW_IR_OUT, CW_PC_LOAD);
      if (op == OP_OUT) return w(CW_A_OUT, CW_OUT_LOAD);
      return '0;
    end
    if (step == 5) begin
      if (op == OP_LDA) return w(CW_RAM_OUT, CW_A_LOAD);
      if (op == OP_ADD || op == OP_SUB) return w(CW_RAM_OUT, CW_B_LOAD);
      if (op == OP_STA) return w(CW_A_OUT, CW_RAM_WE);
      return '0;
    end
    if (op == OP_ADD) return w(CW_ALU_OUT, CW_A_LOAD);
    if (op == OP_SUB) return w(CW_ALU_OUT, CW_A_LOAD, CW_ALU_SUB);
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = EARLY_END=1, index 1 = EARLY_END=0
  always @(posedge clk or negedge clear) begin
    for (int i = 0; i < 2; i++) begin
      if (!clear) begin
        m_step[i] = 1;
        m_halt[i] = 1'b0;
      end else if (run && !m_halt[i]) begin
        if (m_step[i] == 4 && opcode == OP_HLT) m_halt[i] = 1'b1;
        else if ((i == 0 && m_step[i] == m_last(opcode)) || m_step[i] == 6) m_step[i] = 1;
        else m_step[i] = m_step[i] + 1;
      end
    end
  end

  localparam logic [CW_W-1:0] BUS_MASK =
    (CW_W'(1) << CW_PC_OUT) | (CW_W'(1) << CW_RAM_OUT) | (CW_W'(1) << CW_IR_OUT) |
    (CW_W'(1) << CW_A_OUT)  | (CW_W'(1) << CW_ALU_OUT);

  task automatic cmp_dut(input int i, input logic [5:0] ts, input logic h, input logic [CW_W-1:0] cw);
    chk($sformatf("model_t%0d", i), ts, 32'(6'd1 << (m_step[i] - 1)));
    chk($sformatf("model_halted%0d", i), h, m_halt[i]);
    chk($sformatf("model_word%0d", i), cw, m_word(m_step[i], opcode, m_halt[i]));
    chk($sformatf("inv_onehot%0d", i), $onehot(ts), 1);
    chk($sformatf("inv_bus%0d", i), ($countones(cw & BUS_MASK) <= 1), 1);
    chk($sformatf("inv_ram%0d", i), (cw[CW_RAM_WE] && cw[CW_RAM_OUT]), 0);
  endtask

  always @(posedge clk) begin
    #2;
    cmp_dut(0, ts0, h0, cw0);
    cmp_dut(1, ts1, h1, cw1);
  end

  task automatic restart(input logic [3:0] op);
    @(negedge clk);
    opcode = op;
    clear = 1'b0;
    #2;
    clear = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    // Reset with run=1
    repeat (3) @(posedge clk);
    #3;
    chk("reset_t", ts0, 6'b000001);
    chk("reset_halted", h0, 0);
    chk("reset_word", cw0, w(CW_PC_OUT, CW_MAR_LOAD));
    @(negedge clk);
    clear = 1'b1;
    tick(1);
    chk("release_t", ts0, 6'b000010);
    chk("release_word", cw0, w(CW_PC_INC));

    // LDA, EARLY_END=1
    tick(2);
    chk("lda_t4", cw0, w(CW_IR_OUT, CW_MAR_LOAD));
    tick(1);
    chk("lda_t5", cw0, w(CW_RAM_OUT, CW_A_LOAD));
    tick(1);
    chk("lda_end_t", ts0, 6'b000001);
    chk("lda_full_t", ts1, 6'b100000);

    // ADD / SUB / NOP, EARLY_END=0
    restart(OP_ADD);
    tick(5);
    chk("add_t6", cw1, w(CW_ALU_OUT, CW_A_LOAD));
    tick(1);
    chk("add_end_t", ts1, 6'b000001);
    restart(OP_SUB);
    tick(5);
    chk("sub_t6", cw1, w(CW_ALU_OUT, CW_A_LOAD, CW_ALU_SUB));
    tick(1);
    chk("sub_next_t1", cw1, w(CW_PC_OUT, CW_MAR_LOAD));
    restart(4'b0011);
    tick(3);
    chk("nop_t4_word", cw1, 0);
    chk("nop_t4_t", ts1, 6'b001000);
    tick(2);
    chk("nop_t6_t", ts1, 6'b100000);
    chk("nop_t6_word", cw1, 0);
    tick(1);
    chk("nop_end_t", ts1, 6'b000001);

    // JMP, OUT, STA, LDI
    restart(OP_JMP);
    tick(3);
    chk("jmp_t4", cw0, w(CW_IR_OUT, CW_PC_LOAD));
    tick(1);
    chk("jmp_end_t", ts0, 6'b000001);
    restart(OP_OUT);
    tick(3);
    chk("out_t4", cw0, w(CW_A_OUT, CW_OUT_LOAD));
    restart(OP_STA);
    tick(4);
    chk("sta_t5", cw0, w(CW_A_OUT, CW_RAM_WE));
    tick(2);
    restart(OP_LDI);
    tick(6);

    // HLT
    restart(OP_HLT);
    tick(3);
    chk("hlt_t4_word", cw0, 0);
    chk("hlt_t4_halted", h0, 0);
    tick(1);
    chk("hlt_halted", h0, 1);
    chk("hlt_t", ts0, 6'b001000);
    chk("hlt_word", cw0, 0);
    tick(20);
    chk("hlt_hold_t", ts0, 6'b001000);
    chk("hlt_hold_halted", h1, 1);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("hlt_clear_word", cw0, w(CW_PC_OUT, CW_MAR_LOAD));
    chk("hlt_clear_halted", h0, 0);
    chk("hlt_clear_t", ts0, 6'b000001);
    #1;
    clear = 1'b1;

    // Hold during ADD T5
    restart(OP_ADD);
    tick(4);
    run = 1'b0;
    tick(3);
    chk("hold_t", ts1, 6'b010000);
    chk("hold_word", cw1, w(CW_RAM_OUT, CW_B_LOAD));
    run = 1'b1;
    tick(1);
    chk("resume_t", ts1, 6'b100000);

    // Asynchronous clear mid-T5
    restart(OP_ADD);
    tick(4);
    #1;
    clear = 1'b0;
    #1;
    chk("async_t", ts1, 6'b000001);
    chk("async_word", cw1, w(CW_PC_OUT, CW_MAR_LOAD));
    @(negedge clk);
    clear = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
